pipe_stage_hs: RTL

Parametrised, elastic pipeline-stage register. It is the generalised successor of the fixed ID->EX latch. It carries a control bundle and a data bundle between any two stages with a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, synchronous flush for branch squash, and bubble-safe control zeroing. It is instantiated at every stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_skid_slot.sv | 64 ++++++
 rtl/pipe_stage_hs.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and per-boundary bundle widths.
// Every stage register imports this package.
package pipe_pkg;

  localparam int IFID_CTRL_W  = 10;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 10;
  localparam int IDEX_DATA_W  = 32;
  localparam int EXMEM_CTRL_W = 10;
  localparam int EXMEM_DATA_W = 32;
  localparam int MEMWB_CTRL_W = 10;
  localparam int MEMWB_DATA_W = 32;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic [5:0] alu_mode;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+ctrl+data holding register with load and clear-valid.
// Clear zeroes ctrl so a squashed slot never carries live controls.
module pipe_skid_slot #(
  parameter int CTRL_W     = 10,
  parameter int DATA_W     = 32,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  generate
    if (RESET_DATA) begin : g_data_rst
      always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        data_q <= data_d;
      end
    end
  endgenerate

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready stage register: main slot M plus skid slot S,
// with flush squash and a saturating backpressure counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = IDEX_CTRL_W,
  parameter int DATA_W      = IDEX_DATA_W,
  parameter bit RESET_DATA  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;

  logic              accept, emit;
  logic              m_load, m_clr;
  logic              s_load, s_clr;
  logic [CTRL_W-1:0] m_ctrl_in;
  logic [DATA_W-1:0] m_data_in;

  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign in_ready  = !s_valid;
  assign accept    = in_valid && in_ready;
  assign emit      = m_valid && out_ready;
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign stall_cnt = stall_q;

  // S always refills M before a new entry, keeping FIFO order.
  always_comb begin
    m_load    = 1'b0;
    m_clr     = 1'b0;
    s_load    = 1'b0;
    s_clr     = 1'b0;
    m_ctrl_in = in_ctrl;
    m_data_in = in_data;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (!m_valid || emit) begin
      if (s_valid) begin
        m_load    = 1'b1;
        s_clr     = 1'b1;
        m_ctrl_in = s_ctrl;
        m_data_in = s_data;
      end else if (accept) begin
        m_load = 1'b1;
      end else begin
        m_clr = 1'b1;
      end
    end else if (accept) begin
      s_load = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (m_valid && !out_ready && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  pipe_skid_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_m (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .clr     (m_clr),
    .in_ctrl (m_ctrl_in),
    .in_data (m_data_in),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  pipe_skid_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_s (
    .clk     (clk),
    .rst     (rst),
    .load    (s_load),
    .clr     (s_clr),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .valid   (s_valid),
    .ctrl    (s_ctrl),
    .data    (s_data)
  );

endmodule
